// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one half-adder pair plus a carry register,
// LSB first, one bit per cycle, with registered sum/carry-out and a DONE pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_sh, a_sh_d;
  logic [WIDTH-1:0]   b_sh, b_sh_d;
  logic [WIDTH-1:0]   res, res_d;
  logic               carry, carry_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               busy_d, done_d, cout_d;
  logic [WIDTH-1:0]   s_d;

  // Shared half-adder pair working on the current LSBs and the carry register
  logic ha0_sum, ha0_carry, ha1_carry, sum_bit, carry_bit;
  assign ha0_sum   = a_sh[0] ^ b_sh[0];
  assign ha0_carry = a_sh[0] & b_sh[0];
  assign sum_bit   = ha0_sum ^ carry;
  assign ha1_carry = ha0_sum & carry;
  assign carry_bit = ha0_carry | ha1_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_d;
      a_sh  <= a_sh_d;
      b_sh  <= b_sh_d;
      res   <= res_d;
      carry <= carry_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      done  <= done_d;
      s     <= s_d;
      cout  <= cout_d;
    end
  end

  always_comb begin
    state_d = state;
    a_sh_d  = a_sh;
    b_sh_d  = b_sh;
    res_d   = res;
    carry_d = carry;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    s_d     = s;
    cout_d  = cout;

    unique case (state)
      // The FIN cycle doubles as the first idle slot, so a held start gives
      // one operation every WIDTH+1 cycles.
      IDLE, FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh >> 1;
        b_sh_d  = b_sh >> 1;
        res_d   = {sum_bit, res[WIDTH-1:1]};
        carry_d = carry_bit;
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          s_d     = {sum_bit, res[WIDTH-1:1]};
          cout_d  = carry_bit;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, random ops
// against an arithmetic reference, and hand-written timing/reset sequences.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b, s;
  logic         busy, done, cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, want 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for DONE; also counts busy drops and S/COUT changes before it.
  task automatic wait_done(input bit scramble, output int cyc,
                           output int busy_bad, output int hold_bad);
    logic [W-1:0] s0;
    logic         c0;
    s0 = s;
    c0 = cout;
    cyc = -1;
    busy_bad = 0;
    hold_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        a     = W'($urandom);
        b     = W'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      tick();
      if (done) begin
        cyc = k;
        break;
      end
      if (!busy) busy_bad++;
      if (s !== s0 || cout !== c0) hold_bad++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] exp_s, input logic exp_c, input bit scramble);
    int cyc, busy_bad, hold_bad;
    a = aa;
    b = bb;
    start = 1'b1;
    tick();
    start = 1'b0;
    check(tag, "busy_at_E", 32'(busy), 32'd1);
    check(tag, "done_at_E", 32'(done), 32'd0);
    wait_done(scramble, cyc, busy_bad, hold_bad);
    check(tag, "latency", 32'(cyc), 32'(W));
    check(tag, "busy_gaps", 32'(busy_bad), 32'd0);
    check(tag, "hold_run", 32'(hold_bad), 32'd0);
    check(tag, "busy_at_done", 32'(busy), 32'd0);
    check(tag, "s", 32'(s), 32'(exp_s));
    check(tag, "cout", 32'(cout), 32'(exp_c));
    tick();
    check(tag, "done_width", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, busy_bad, hold_bad, cnt;
    logic [W:0]   ref_sum;
    logic [W-1:0] ra, rb, s_hold;
    logic         c_hold;

    vecs[0] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    vecs[1] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};
    vecs[6] = '{a: 8'h0F, b: 8'hF1, s: 8'h00, c: 1'b1};
    vecs[7] = '{a: 8'h12, b: 8'h34, s: 8'h46, c: 1'b0};

    // Reset state, with start already high while reset is asserted
    rst_n = 1'b1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    #1 rst_n = 1'b0;
    #1;
    check("reset", "busy", 32'(busy), 32'd0);
    check("reset", "done", 32'(done), 32'd0);
    check("reset", "s", 32'(s), 32'd0);
    check("reset", "cout", 32'(cout), 32'd0);

    // Start high across reset release is accepted at the first edge
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    check("rel_start", "busy_at_E", 32'(busy), 32'd1);
    wait_done(1'b0, cyc, busy_bad, hold_bad);
    check("rel_start", "latency", 32'(cyc), 32'(W));
    check("rel_start", "s", 32'(s), 32'h00);
    check("rel_start", "cout", 32'(cout), 32'd1);
    tick();

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b0);

    // Hold through idle cycles
    s_hold = s;
    c_hold = cout;
    cnt = 0;
    repeat (25) begin
      tick();
      if (s !== s_hold || cout !== c_hold || done || busy) cnt++;
    end
    check("idle_hold", "changes", 32'(cnt), 32'd0);

    // Random operands against plain arithmetic, half with scrambled inputs mid-run
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      run_op($sformatf("rnd%0d", i), ra, rb, ref_sum[W-1:0], ref_sum[W], bit'(i % 2));
    end

    // Back-to-back with start held high
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    tick();
    a = 8'h80;
    b = 8'h80;
    check("b2b", "busy_at_E", 32'(busy), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        cyc = k;
        break;
      end
      cyc = -1;
    end
    check("b2b", "latency1", 32'(cyc), 32'(W));
    check("b2b", "s1", 32'(s), 32'h10);
    check("b2b", "cout1", 32'(cout), 32'd0);
    tick();
    check("b2b", "accept2", 32'(busy), 32'd1);
    check("b2b", "done_low", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(1'b0, cyc, busy_bad, hold_bad);
    check("b2b", "spacing", 32'(cyc + 1), 32'(W + 1));
    check("b2b", "s2", 32'(s), 32'h00);
    check("b2b", "cout2", 32'(cout), 32'd1);
    tick();

    // Operand stability with start pulses during RUN
    run_op("stable", 8'h3C, 8'h03, 8'h3F, 1'b0, 1'b1);
    cnt = 0;
    repeat (12) begin
      tick();
      if (done || busy) cnt++;
    end
    check("stable", "extra_op", 32'(cnt), 32'd0);

    // Reset abort mid-RUN
    run_op("pre_abort", 8'h55, 8'h22, 8'h77, 1'b0, 1'b0);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort", "busy", 32'(busy), 32'd0);
    check("abort", "done", 32'(done), 32'd0);
    check("abort", "s", 32'(s), 32'd0);
    check("abort", "cout", 32'(cout), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      tick();
      if (done || busy) cnt++;
    end
    check("abort", "no_done", 32'(cnt), 32'd0);
    run_op("post_abort", 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
